// File: rtl/somador_subtrator_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : somador_subtrator_pipe_if
// Description : Handshake and data bundle for the pipelined adder/subtractor.
//               Input side : in_valid/in_ready, subtraindo, A, B.
//               Output side: out_valid/out_ready, S, cout, zero, negative,
//                            overflow.
//               master = producer of operations / consumer of results.
//               slave  = the pipelined adder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface somador_subtrator_pipe_if #(
    parameter int BITS = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            subtraindo;
    logic [BITS-1:0] A;
    logic [BITS-1:0] B;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] S;
    logic            cout;
    logic            zero;
    logic            negative;
    logic            overflow;

    modport master (
        output in_valid, subtraindo, A, B, out_ready,
        input  in_ready, out_valid, S, cout, zero, negative, overflow
    );

    modport slave (
        input  in_valid, subtraindo, A, B, out_ready,
        output in_ready, out_valid, S, cout, zero, negative, overflow
    );
endinterface
`default_nettype wire

// File: rtl/somador_subtrator_pipe.sv
`default_nettype none
// ============================================================================
// Module      : somador_subtrator_pipe
// Description : Pipelined BITS-wide adder/subtractor. The carry chain is cut
//               into STAGES chunks of W = BITS/STAGES bits; stage k sums
//               chunk k using the registered carry from stage k-1. Unsummed
//               operand chunks and already-summed result chunks travel with
//               each operation. A global advance signal stalls every stage
//               when the output is held.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - slave modport: in_valid/in_ready, subtraindo, A, B,
//                       out_valid/out_ready, S, cout, zero, negative,
//                       overflow
// Revision    : 1.0 - initial release
// ============================================================================
module somador_subtrator_pipe #(
    parameter int BITS   = 64,
    parameter int STAGES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    somador_subtrator_pipe_if.slave  bus
);
    localparam int W = BITS / STAGES;

    if (BITS < 2 || STAGES < 1 || (BITS % STAGES) != 0) begin : g_param_check
        $error("somador_subtrator_pipe: BITS must be >= 2 and divisible by STAGES");
    end

    logic            w_adv;
    logic [BITS-1:0] w_b_eff;

    // The whole pipe moves together: it advances unless the result is held.
    assign w_adv        = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = w_adv;

    // Subtraction is A + ~B + 1; the +1 enters as the carry-in of stage 0.
    assign w_b_eff = bus.subtraindo ? ~bus.B : bus.B;

    // Each stage register packs {A_rem, B_rem, S_done}: the operand chunks
    // still to be summed and the result chunks already produced. Entering
    // stage k there are REMI = BITS-k*W operand bits left, so the vector is
    // BITS+REMI wide; the final stage register holds just the full sum.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONEI = k * W;
        localparam int REMI  = BITS - DONEI;
        localparam int REMO  = REMI - W;

        logic [BITS+REMI-1:0] w_src;
        logic                 w_v_src;
        logic                 w_c_src;
        logic [W-1:0]         w_a_chk;
        logic [W-1:0]         w_b_chk;
        logic [W:0]           w_sum;
        logic [BITS+REMO-1:0] w_nxt;

        logic                 r_v;
        logic                 r_c;
        logic [BITS+REMO-1:0] r_abs;

        if (k == 0) begin : g_head
            assign w_src   = {bus.A, w_b_eff};
            assign w_v_src = bus.in_valid;
            assign w_c_src = bus.subtraindo;
        end else begin : g_body
            assign w_src   = g_stage[k-1].r_abs;
            assign w_v_src = g_stage[k-1].r_v;
            assign w_c_src = g_stage[k-1].r_c;
        end

        assign w_a_chk = w_src[BITS +: W];
        assign w_b_chk = w_src[DONEI +: W];
        assign w_sum   = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{W{1'b0}}, w_c_src};

        // Keep finished chunks in place, drop the new chunk in above them,
        // keep the upper B chunks in place and slide the upper A chunks
        // down by W so A_rem always starts at bit BITS.
        always_comb begin
            w_nxt = '0;
            for (int i = 0; i < DONEI; i++) begin
                w_nxt[i] = w_src[i];
            end
            for (int i = 0; i < W; i++) begin
                w_nxt[DONEI+i] = w_sum[i];
            end
            for (int i = 0; i < REMO; i++) begin
                w_nxt[DONEI+W+i]      = w_src[DONEI+W+i];
                w_nxt[DONEI+W+REMO+i] = w_src[BITS+W+i];
            end
        end

        // Data only loads with a valid operation so bubbles never disturb
        // the held contents and undriven inputs cannot leak X downstream.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_abs <= '0;
            end else if (w_adv) begin
                r_v <= w_v_src;
                if (w_v_src) begin
                    r_c   <= w_sum[W];
                    r_abs <= w_nxt;
                end
            end
        end
    end

    logic            w_last_v;
    logic [BITS-1:0] w_last_s;
    logic            w_last_cin_top;
    logic            w_last_ovf;
    logic            r_zero;
    logic            r_ovf;

    assign w_last_v = g_stage[STAGES-1].w_v_src;
    assign w_last_s = g_stage[STAGES-1].w_nxt;

    // Carry into bit BITS-1 recovered from the top bit of the final chunk:
    // sum = a ^ b ^ carry_in for that bit.
    assign w_last_cin_top = g_stage[STAGES-1].w_sum[W-1]
                          ^ g_stage[STAGES-1].w_a_chk[W-1]
                          ^ g_stage[STAGES-1].w_b_chk[W-1];
    assign w_last_ovf     = w_last_cin_top ^ g_stage[STAGES-1].w_sum[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_adv && w_last_v) begin
            r_zero <= (w_last_s == '0);
            r_ovf  <= w_last_ovf;
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_v;
    assign bus.S         = g_stage[STAGES-1].r_abs;
    assign bus.cout      = g_stage[STAGES-1].r_c;
    assign bus.negative  = g_stage[STAGES-1].r_abs[BITS-1];
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: doc/somador_subtrator_pipe.md
SOMADOR_SUBTRATOR_PIPE -- requirements
Module: somador_subtrator_pipe

Interface
REQ-001 Parameter BITS, default 64: operand and result width; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; SHALL divide BITS exactly; chunk width W = BITS/STAGES.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation offered this cycle.
REQ-006 in_ready  output  1  block accepts the offered operation this cycle.
REQ-007 subtraindo  input  1  1 = A-B, 0 = A+B; sampled with A/B on acceptance.
REQ-008 A  input  BITS  first operand.
REQ-009 B  input  BITS  second operand.
REQ-010 out_valid  output  1  result on S/flags is valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 S  output  BITS  result, modulo 2^BITS.
REQ-013 cout  output  1  carry out of bit BITS-1.
REQ-014 zero  output  1  S == 0.
REQ-015 negative  output  1  S[BITS-1].
REQ-016 overflow  output  1  two's-complement signed overflow.

Function
REQ-017 Arithmetic SHALL be A + (subtraindo ? ~B : B) + subtraindo; full carry chain across BITS bits.
REQ-018 For subtraction, cout SHALL be 1 exactly when A >= B unsigned (no borrow).
REQ-019 overflow SHALL equal carry into bit BITS-1 XOR cout.
REQ-020 Stage k (0..STAGES-1) SHALL compute chunk bits [k*W+W-1 : k*W] from the registered carry out of stage k-1; stage 0 uses carry-in = subtraindo.
REQ-021 Operand chunks not yet summed and result chunks already summed SHALL travel with their operation through the stage registers.
REQ-022 Latency SHALL be exactly STAGES cycles from accepting edge to out_valid high, with no stall.
REQ-023 Throughput SHALL be one operation per cycle when out_ready stays high.
REQ-024 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-025 Stall: when out_valid=1 and out_ready=0, every stage register SHALL hold; in_ready SHALL be 0.
REQ-026 in_ready SHALL equal out_ready || !out_valid (combinational, no dependence on in_valid).
REQ-027 Each stage SHALL carry a valid bit; an empty slot (bubble) SHALL advance without affecting outputs or neighbours.
REQ-028 While out_valid=0, S/cout/flags are don't-care to the consumer but SHALL NOT produce X after reset.
REQ-029 S, cout, zero, negative, overflow SHALL be registered outputs of the final stage, stable while stalled.
REQ-030 Operations SHALL leave in acceptance order; none dropped or duplicated.
REQ-031 STAGES=1 SHALL degenerate to a single-register adder with latency 1.

Reset
REQ-032 rst_n low SHALL immediately clear all stage valid bits; out_valid=0, S=0, cout=0, zero=0, negative=0, overflow=0.
REQ-033 Reset mid-operation SHALL discard all in-flight operations; none emerge after release.
REQ-034 First acceptance SHALL be possible on the first rising edge with rst_n high; in_ready=1 during and after reset.

Verification (BITS=64, STAGES=4, out_ready=1 unless stated)
REQ-035 A=5, B=3, sub=0 accepted at cycle 0 -> cycle 4: out_valid=1, S=8, cout=0, zero=0, negative=0, overflow=0.
REQ-036 A=3, B=5, sub=1 -> S=0xFFFF_FFFF_FFFF_FFFE, cout=0, negative=1, overflow=0; A=5, B=5, sub=1 -> S=0, zero=1, cout=1.
REQ-037 A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> S=0x8000_0000_0000_0000, overflow=1, negative=1; A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> S=0, cout=1, zero=1 (carry ripples across all 4 stages).
REQ-038 Back-to-back stream of 8 random ops, out_ready low for cycles 6-8 -> in_ready low exactly when out_valid=1 and out_ready=0; all 8 results match the model in order; held outputs stable.
REQ-039 Accept 3 ops, assert rst_n low for one cycle mid-flight -> out_valid=0 immediately, no result after release; next op returns correctly after 4 cycles.
REQ-040 Repeat REQ-035..REQ-037 at BITS=32, STAGES=1 and BITS=16, STAGES=16 -> identical arithmetic, latency equals STAGES.
